raster_timing: RTL

Generates the 1280x720@60 raster timing that every Pong drawing block consumes: signed `hpos`/`vpos`, `active`, `fsync`, and the HDMI `hsync`/`vsync`. It sits inside the HDMI path on `pixel_clk` as the producer side of the shared video interface. The object, paddle, scoreboard and game-over logic are its consumers. Blanking is mapped to negative coordinates, so consumers test for the visible area with `hpos >= 0 && vpos >= 0`.

---
 rtl/pong_video_pkg.sv | 26 ++
 rtl/raster_axis_counter.sv | 54 +++++
 rtl/raster_timing.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pong_video_pkg.sv
// Shared 720p raster constants, coordinate type and colour helper for the Pong video path.
package pong_video_pkg;

  typedef logic signed [11:0] coord_t;
  typedef logic [2:0][7:0]    rgb_t;

  localparam int HRES   = 1280;
  localparam int VRES   = 720;
  localparam int H_FP   = 110;
  localparam int H_SYNC = 40;
  localparam int H_BP   = 220;
  localparam int V_FP   = 5;
  localparam int V_SYNC = 5;
  localparam int V_BP   = 20;

  // Blanking sits at negative coordinates, so each axis starts at minus its blank length.
  localparam int H_MIN   = -(H_FP + H_SYNC + H_BP);
  localparam int V_MIN   = -(V_FP + V_SYNC + V_BP);
  localparam int H_TOTAL = HRES - H_MIN;
  localparam int V_TOTAL = VRES - V_MIN;

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
  endfunction

endpackage

// File: rtl/raster_axis_counter.sv
// One raster axis: signed position counter from MIN to MAX with wrap strobe and registered sync window.
module raster_axis_counter
  import pong_video_pkg::*;
#(
  parameter int MIN        = -8,
  parameter int MAX        = 7,
  parameter int SYNC_START = -6,
  parameter int SYNC_LEN   = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   inc,
  output coord_t pos,
  output coord_t pos_next,
  output logic   wrap,
  output logic   sync_on
);

  localparam coord_t MIN_C      = coord_t'(MIN);
  localparam coord_t MAX_C      = coord_t'(MAX);
  localparam coord_t SYNC_FIRST = coord_t'(SYNC_START);
  localparam coord_t SYNC_LAST  = coord_t'(SYNC_START + SYNC_LEN - 1);

  coord_t pos_q, pos_d;
  logic   syncOn_q, syncOn_d;

  assign wrap = inc && (pos_q == MAX_C);

  always_comb begin
    pos_d = pos_q;
    if (wrap) begin
      pos_d = MIN_C;
    end else if (inc) begin
      pos_d = pos_q + coord_t'(1);
    end
    syncOn_d = (pos_d >= SYNC_FIRST) && (pos_d <= SYNC_LAST);
  end

  // Sync is decoded from the next position so it lands on the same cycle as that position.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q    <= MIN_C;
      syncOn_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      syncOn_q <= syncOn_d;
    end
  end

  assign pos      = pos_q;
  assign pos_next = pos_d;
  assign sync_on  = syncOn_q;

endmodule

// File: rtl/raster_timing.sv
// 1280x720@60 raster generator: signed coordinates, active, fsync and HDMI syncs, all registered.
// Optional colour-bar test pattern is built only when RASTER_TEST_PATTERN_EN is defined.
module raster_timing
  import pong_video_pkg::coord_t, pong_video_pkg::rgb_t, pong_video_pkg::bar_colour;
#(
  parameter int HRES     = pong_video_pkg::HRES,
  parameter int VRES     = pong_video_pkg::VRES,
  parameter int H_FP     = pong_video_pkg::H_FP,
  parameter int H_SYNC   = pong_video_pkg::H_SYNC,
  parameter int H_BP     = pong_video_pkg::H_BP,
  parameter int V_FP     = pong_video_pkg::V_FP,
  parameter int V_SYNC   = pong_video_pkg::V_SYNC,
  parameter int V_BP     = pong_video_pkg::V_BP,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic   pixel_clk,
  input  logic   rst,
  output coord_t hpos,
  output coord_t vpos,
  output logic   active,
  output logic   fsync,
  output logic   hsync,
  output logic   vsync,
  output rgb_t   pattern
);

  localparam int H_MIN = -(H_FP + H_SYNC + H_BP);
  localparam int V_MIN = -(V_FP + V_SYNC + V_BP);

  if (H_MIN < -2048 || HRES > 2047) begin : gHRangeErr
    $error("raster_timing: horizontal range does not fit a 12-bit signed coordinate");
  end
  if (V_MIN < -2048 || VRES > 2047) begin : gVRangeErr
    $error("raster_timing: vertical range does not fit a 12-bit signed coordinate");
  end

  logic   start_q;
  coord_t hPos, hNext, vPos, vNext;
  logic   hWrap, vWrap, hSyncOn, vSyncOn;
  logic   active_q, active_d;
  logic   fsync_q, fsync_d;

  raster_axis_counter #(
    .MIN       (H_MIN),
    .MAX       (HRES - 1),
    .SYNC_START(H_MIN + H_FP),
    .SYNC_LEN  (H_SYNC)
  ) uHAxis (
    .clk     (pixel_clk),
    .rst     (rst),
    .inc     (!start_q),
    .pos     (hPos),
    .pos_next(hNext),
    .wrap    (hWrap),
    .sync_on (hSyncOn)
  );

  raster_axis_counter #(
    .MIN       (V_MIN),
    .MAX       (VRES - 1),
    .SYNC_START(V_MIN + V_FP),
    .SYNC_LEN  (V_SYNC)
  ) uVAxis (
    .clk     (pixel_clk),
    .rst     (rst),
    .inc     (hWrap),
    .pos     (vPos),
    .pos_next(vNext),
    .wrap    (vWrap),
    .sync_on (vSyncOn)
  );

  // The first edge after reset holds both axes at their minimum, opening a full frame with fsync.
  assign active_d = (hNext >= coord_t'(0)) && (vNext >= coord_t'(0));
  assign fsync_d  = start_q || vWrap;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      start_q  <= 1'b1;
      active_q <= 1'b0;
      fsync_q  <= 1'b0;
    end else begin
      start_q  <= 1'b0;
      active_q <= active_d;
      fsync_q  <= fsync_d;
    end
  end

  assign hpos   = hPos;
  assign vpos   = vPos;
  assign active = active_q;
  assign fsync  = fsync_q;
  assign hsync  = SYNC_POL ? hSyncOn : !hSyncOn;
  assign vsync  = SYNC_POL ? vSyncOn : !vSyncOn;

`ifdef RASTER_TEST_PATTERN_EN
  localparam int BAR_W = HRES / 8;

  logic [2:0] barIdx;
  rgb_t       pattern_q, pattern_d;

  always_comb begin
    barIdx    = 3'(hNext / coord_t'(BAR_W));
    pattern_d = active_d ? bar_colour(barIdx) : '0;
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      pattern_q <= '0;
    end else begin
      pattern_q <= pattern_d;
    end
  end

  assign pattern = pattern_q;
`else
  assign pattern = '0;
`endif

endmodule
